// File: rtl/fc1_sched_pkg.sv
// Shared types and helpers for the fc1 timestep scheduler.
package fc1_sched_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain,
    StDone
  } sched_state_e;

  // Highest number of kernel starts that may be outstanding at once.
  localparam int unsigned MaxOutLimit = 3;

  function automatic bit max_out_legal(input int unsigned max_out);
    return (max_out >= 1) && (max_out <= MaxOutLimit);
  endfunction

  function automatic int unsigned sat_steps(input int unsigned cfg, input int unsigned max_steps);
    return (cfg > max_steps) ? max_steps : cfg;
  endfunction

endpackage

// File: rtl/fc1_sched_perf_cnt.sv
// Saturating counter pair for scheduler performance monitoring.
// Only built when FC1_SCHED_PERF_EN is defined.
`ifdef FC1_SCHED_PERF_EN
module fc1_sched_perf_cnt #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc_a,
  input  logic         inc_b,
  output logic [W-1:0] cnt_a,
  output logic [W-1:0] cnt_b
);

  logic [W-1:0] cnt_a_q, cnt_b_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else if (clr) begin
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else begin
      if (inc_a && (cnt_a_q != '1)) cnt_a_q <= cnt_a_q + 1'b1;
      if (inc_b && (cnt_b_q != '1)) cnt_b_q <= cnt_b_q + 1'b1;
    end
  end

  assign cnt_a = cnt_a_q;
  assign cnt_b = cnt_b_q;

endmodule
`endif

// File: rtl/fc1_timestep_sched.sv
// Drives the fc1 MVAU kernel (ap_ctrl_chain) once per SNN timestep of a frame.
// FC1_SCHED_PERF_EN adds perf_cycles / perf_stall counters.
module fc1_timestep_sched
  import fc1_sched_pkg::*;
#(
  parameter int unsigned NUM_STEPS = 8,
  parameter int unsigned STEP_W    = $clog2(NUM_STEPS + 1),
  parameter int unsigned MAX_OUT   = 2
`ifdef FC1_SCHED_PERF_EN
  ,
  parameter int unsigned CYC_W     = 32
`endif
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              frame_req,
  output logic              frame_ack,
  input  logic [STEP_W-1:0] steps_cfg,
  input  logic              abort,
  output logic              mvau_ap_start,
  input  logic              mvau_ap_ready,
  input  logic              mvau_ap_done,
  output logic              mvau_ap_continue,
  output logic [STEP_W-1:0] step_idx,
  output logic              step_last,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_aborted
`ifdef FC1_SCHED_PERF_EN
  ,
  output logic [CYC_W-1:0]  perf_cycles,
  output logic [CYC_W-1:0]  perf_stall
`endif
);

  localparam logic [STEP_W:0] MaxOutW = (STEP_W + 1)'(MAX_OUT);

  sched_state_e      state_q, state_d;
  logic [STEP_W-1:0] steps_q, steps_d;
  logic [STEP_W-1:0] iss_q, iss_d;
  logic [STEP_W-1:0] cmp_q, cmp_d;
  logic              start_q, start_d;
  logic              aborted_q, aborted_d;
  logic              hs, done_ok, abort_any;
  logic [STEP_W:0]   in_flight;

  assign hs               = start_q & mvau_ap_ready;
  assign mvau_ap_continue = (state_q == StIssue) || (state_q == StDrain);
  // A done with nothing outstanding cannot belong to any start we issued.
  assign done_ok          = mvau_ap_done & mvau_ap_continue & (cmp_q != iss_q);
  assign abort_any        = abort | aborted_q;

  always_comb begin
    state_d   = state_q;
    steps_d   = steps_q;
    iss_d     = iss_q;
    cmp_d     = cmp_q;
    aborted_d = aborted_q;
    start_d   = 1'b0;
    frame_ack = 1'b0;
    if (hs)      iss_d = iss_q + 1'b1;
    if (done_ok) cmp_d = cmp_q + 1'b1;
    in_flight = {1'b0, iss_d} - {1'b0, cmp_d};

    unique case (state_q)
      StIdle: begin
        frame_ack = frame_req;
        if (frame_req) begin
          steps_d   = STEP_W'(sat_steps(32'(steps_cfg), NUM_STEPS));
          iss_d     = '0;
          cmp_d     = '0;
          aborted_d = 1'b0;
          state_d   = (steps_d == '0) ? StDone : StIssue;
        end
      end
      StIssue: begin
        aborted_d = aborted_q | abort;
        // A pending start is never withdrawn, even by abort.
        if (start_q && !mvau_ap_ready) begin
          start_d = 1'b1;
        end else begin
          start_d = (iss_d < steps_q) && (in_flight < MaxOutW) && !abort_any;
        end
        if ((iss_d == steps_q) || (abort_any && !start_d)) state_d = StDrain;
      end
      StDrain: begin
        if (cmp_d == iss_q) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q   <= StIdle;
      steps_q   <= '0;
      iss_q     <= '0;
      cmp_q     <= '0;
      start_q   <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      steps_q   <= steps_d;
      iss_q     <= iss_d;
      cmp_q     <= cmp_d;
      start_q   <= start_d;
      aborted_q <= aborted_d;
    end
  end

  assign mvau_ap_start = start_q;
  assign step_idx      = iss_q;
  assign step_last     = start_q && (iss_q == (steps_q - 1'b1));
  assign busy          = (state_q != StIdle);
  assign frame_done    = (state_q == StDone);
  assign frame_aborted = (state_q == StDone) && aborted_q;

`ifdef FC1_SCHED_PERF_EN
  fc1_sched_perf_cnt #(
    .W (CYC_W)
  ) u_perf_cnt (
    .clk   (ap_clk),
    .rst_n (ap_rst_n),
    .clr   (frame_ack),
    .inc_a (busy),
    .inc_b (mvau_ap_start & ~mvau_ap_ready),
    .cnt_a (perf_cycles),
    .cnt_b (perf_stall)
  );
`endif

`ifndef SYNTHESIS
  always_ff @(posedge ap_clk) begin
    if (ap_rst_n) begin
      a_max_out_legal: assert (max_out_legal(MAX_OUT));
      a_done_without_start: assert (!(mvau_ap_done && mvau_ap_continue && (cmp_q == iss_q)));
    end
  end
`endif

endmodule

// File: tb/tb_fc1_timestep_sched.sv
// Directed bench for fc1_timestep_sched with a small ap_ctrl_chain kernel model.
module tb_fc1_timestep_sched;

  localparam int unsigned StepW  = 4;
  localparam int          MaxOut = 2;

  logic             ap_clk    = 1'b0;
  logic             ap_rst_n  = 1'b0;
  logic             frame_req = 1'b0;
  logic             abort     = 1'b0;
  logic [StepW-1:0] steps_cfg = '0;
  logic             mvau_ap_done = 1'b0;
  logic             frame_ack, mvau_ap_start, mvau_ap_ready, mvau_ap_continue;
  logic [StepW-1:0] step_idx;
  logic             step_last, busy, frame_done, frame_aborted;
`ifdef FC1_SCHED_PERF_EN
  logic [31:0]      perf_cycles, perf_stall;
`endif

  logic ready_en   = 1'b1;
  logic done_en    = 1'b1;
  int   done_delay = 5;
  int   cyc        = 0;
  int   due_q[$];

  int   errors = 0;
  int   checks = 0;
  int   hs_cnt = 0, dn_cnt = 0, fd_cnt = 0, same_cnt = 0, start_cnt = 0, max_infl = 0;
  int   ack_cyc = -1, first_start_cyc = 0, last_done_cyc = 0, fd_cyc = 0;
  logic fd_aborted = 1'b0;
  int   exp_last = 7;

  always #5 ap_clk = ~ap_clk;
  assign mvau_ap_ready = ready_en;

  fc1_timestep_sched u_dut (
    .ap_clk           (ap_clk),
    .ap_rst_n         (ap_rst_n),
    .frame_req        (frame_req),
    .frame_ack        (frame_ack),
    .steps_cfg        (steps_cfg),
    .abort            (abort),
    .mvau_ap_start    (mvau_ap_start),
    .mvau_ap_ready    (mvau_ap_ready),
    .mvau_ap_done     (mvau_ap_done),
    .mvau_ap_continue (mvau_ap_continue),
    .step_idx         (step_idx),
    .step_last        (step_last),
    .busy             (busy),
    .frame_done       (frame_done),
    .frame_aborted    (frame_aborted)
`ifdef FC1_SCHED_PERF_EN
    ,
    .perf_cycles      (perf_cycles),
    .perf_stall       (perf_stall)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Kernel model: one done per cycle, done_delay cycles after each accepted start.
  always @(negedge ap_clk) begin
    cyc++;
    if (!ap_rst_n) due_q.delete();
    mvau_ap_done = ap_rst_n && done_en && (due_q.size() > 0) && (due_q[0] <= cyc);
  end

  always @(posedge ap_clk) begin
    if (ap_rst_n) begin
      if (frame_ack) ack_cyc = cyc;
      if (mvau_ap_start) begin
        if (start_cnt == 0) first_start_cyc = cyc;
        start_cnt++;
        check("step_last", step_last, step_idx == exp_last);
      end
      if (mvau_ap_start && mvau_ap_ready) begin
        check("step_idx", step_idx, hs_cnt);
        hs_cnt++;
        due_q.push_back(cyc + done_delay);
      end
      if (mvau_ap_done && mvau_ap_continue) begin
        void'(due_q.pop_front());
        dn_cnt++;
        last_done_cyc = cyc;
        if (mvau_ap_start && mvau_ap_ready) same_cnt++;
      end
      if (hs_cnt - dn_cnt > max_infl) max_infl = hs_cnt - dn_cnt;
      if (frame_done) begin
        fd_cnt++;
        fd_cyc     = cyc;
        fd_aborted = frame_aborted;
      end
    end
  end

  task automatic new_frame(input logic [StepW-1:0] cfg, input int last);
    int n;
    hs_cnt = 0; dn_cnt = 0; fd_cnt = 0; same_cnt = 0; start_cnt = 0; max_infl = 0;
    ack_cyc = -1;
    exp_last  = last;
    steps_cfg = cfg;
    frame_req = 1'b1;
    n = 0;
    while (ack_cyc < 0 && n < 20) begin
      @(negedge ap_clk);
      n++;
    end
    check("frame_ack_seen", ack_cyc >= 0, 1);
    frame_req = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (fd_cnt == 0 && n < budget) begin
      @(negedge ap_clk);
      n++;
    end
    check("frame_done_timeout", fd_cnt > 0, 1);
  endtask

  task automatic wait_start(input string tag);
    int n;
    n = 0;
    while (!mvau_ap_start && n < 100) begin
      @(negedge ap_clk);
      n++;
    end
    check(tag, mvau_ap_start, 1);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge ap_clk);
    check("reset_outputs",
          {frame_ack, mvau_ap_start, mvau_ap_continue, step_idx, step_last, busy, frame_done,
           frame_aborted}, 0);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);

    // 8 steps, immediate ready, done 5 cycles after ready
    done_delay = 5;
    new_frame(4'd8, 7);
    wait_done(300);
    check("t1_handshakes", hs_cnt, 8);
    check("t1_dones", dn_cnt, 8);
    check("t1_ack_to_start", first_start_cyc - ack_cyc, 2);
    check("t1_done_latency", fd_cyc - last_done_cyc, 1);
    check("t1_aborted", fd_aborted, 0);
    check("t1_max_inflight", max_infl, MaxOut);
    @(negedge ap_clk);
    check("t1_busy_after", busy, 0);
    check("t1_done_once", fd_cnt, 1);

    // done withheld: in-flight limit stops issue
    done_en = 1'b0;
    new_frame(4'd8, 7);
    repeat (20) @(negedge ap_clk);
    check("t2_handshakes_held", hs_cnt, 2);
    check("t2_start_cycles", start_cnt, 2);
    check("t2_start_low", mvau_ap_start, 0);
    check("t2_continue", mvau_ap_continue, 1);
    done_en = 1'b1;
    wait_done(300);
    check("t2_handshakes", hs_cnt, 8);
    check("t2_max_inflight", max_infl <= MaxOut, 1);

    // zero steps, then saturation of 12 to 8
    new_frame(4'd0, 0);
    wait_done(20);
    check("t3_zero_done_latency", fd_cyc - ack_cyc, 1);
    check("t3_zero_no_start", start_cnt, 0);
    new_frame(4'd12, 7);
    wait_done(300);
    check("t3_sat_handshakes", hs_cnt, 8);

    // abort while a start is pending and ready is low
    done_delay = 3;
    new_frame(4'd8, 7);
    n = 0;
    while (hs_cnt < 2 && n < 100) begin
      @(negedge ap_clk);
      n++;
    end
    check("t4_two_handshakes", hs_cnt, 2);
    ready_en = 1'b0;
    wait_start("t4_start_pending");
    abort = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge ap_clk);
      check("t4_start_held", mvau_ap_start, 1);
    end
    abort    = 1'b0;
    ready_en = 1'b1;
    wait_done(300);
    check("t4_handshakes", hs_cnt, 3);
    check("t4_dones", dn_cnt, 3);
    check("t4_aborted", fd_aborted, 1);
    check("t4_done_latency", fd_cyc - last_done_cyc, 1);

    // ready and done in the same cycle
    done_delay = 1;
    new_frame(4'd8, 7);
    wait_done(300);
    check("t5_handshakes", hs_cnt, 8);
    check("t5_dones", dn_cnt, 8);
    check("t5_same_cycle", same_cnt >= 4, 1);
    check("t5_max_inflight", max_infl <= MaxOut, 1);

    // reset in the middle of a frame
    done_delay = 5;
    new_frame(4'd8, 7);
    n = 0;
    while (!(mvau_ap_start && step_idx == 4) && n < 200) begin
      @(negedge ap_clk);
      n++;
    end
    check("t6_reached_step4", step_idx, 4);
    ap_rst_n = 1'b0;
    @(negedge ap_clk);
    check("t6_reset_outputs",
          {frame_ack, mvau_ap_start, mvau_ap_continue, step_idx, step_last, busy, frame_done,
           frame_aborted}, 0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    new_frame(4'd3, 2);
    wait_done(300);
    check("t6_handshakes", hs_cnt, 3);
    check("t6_aborted", fd_aborted, 0);

`ifdef FC1_SCHED_PERF_EN
    ready_en = 1'b0;
    new_frame(4'd2, 1);
    wait_start("perf_start_pending");
    repeat (10) @(negedge ap_clk);
    ready_en = 1'b1;
    wait_done(300);
    check("perf_stall", perf_stall, 10);
    repeat (5) @(negedge ap_clk);
    check("perf_stall_hold", perf_stall, 10);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
